// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: funct3 op codes,
// FSM state encoding and a counter-width helper.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MDS_IDLE,
    MDS_MUL_WAIT,
    MDS_DIV_ITER,
    MDS_DIV_FIX
  } md_state_e;

  // One counter serves both the multiply latency and the divide step count.
  function automatic int unsigned cnt_width(input int unsigned xlen,
                                            input int unsigned mul_cycles);
    int unsigned max_cnt;
    max_cnt = (xlen > mul_cycles) ? xlen : mul_cycles;
    return $clog2(max_cnt) + 1;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One combinational restoring-division iteration: shifts the next dividend
// bit into the partial remainder and produces one quotient bit.
module muldiv_sequencer_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] dvsr,
  input  logic [XLEN-1:0] q_in,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] q_out
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    shifted = {rem_in, q_in[XLEN-1]};
    diff    = shifted - {2'b00, dvsr};
    if (diff[XLEN+1]) begin
      rem_out = shifted[XLEN:0];
      q_out   = {q_in[XLEN-2:0], 1'b0};
    end else begin
      rem_out = diff[XLEN:0];
      q_out   = {q_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide controller that stalls EX until done.
// Optional MULDIV_EARLY_OUT_EN shortcuts div-by-zero, signed overflow and zero multiplies.
module muldiv_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import muldiv_sequencer_pkg::*;

  localparam int unsigned CNT_W = cnt_width(XLEN, MUL_CYCLES);

  md_state_e       state, state_n;
  md_op_e          op_e;
  logic [CNT_W-1:0] cnt;
  logic            fix_ph;
  logic [XLEN-1:0] res_stage, result_q, a_q, q_reg, dvsr;
  logic [XLEN:0]   rem_reg, rem_nx;
  logic [XLEN-1:0] q_nx;
  logic            neg_q, neg_r, is_rem, b_zero, ovf;
  logic            accept;

  logic            in_signed, a_neg_in, b_neg_in, in_b_zero, in_ovf;
  logic [XLEN-1:0] a_mag_in, b_mag_in, mul_res, div_res;
  logic signed [2*XLEN-1:0] mul_a, mul_b, product;
  logic            div_skip, mul_zero;

  assign op_e = md_op_e'(op);

  always_comb begin
    in_signed = ~op[0];
    a_neg_in  = in_signed & a[XLEN-1];
    b_neg_in  = in_signed & b[XLEN-1];
    a_mag_in  = a_neg_in ? -a : a;
    b_mag_in  = b_neg_in ? -b : b;
    in_b_zero = (b == '0);
    in_ovf    = in_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // The high-half ops differ only in which operands are sign-extended.
    mul_a     = {{XLEN{((op_e == MD_MULH) || (op_e == MD_MULHSU)) && a[XLEN-1]}}, a};
    mul_b     = {{XLEN{(op_e == MD_MULH) && b[XLEN-1]}}, b};
    product   = mul_a * mul_b;
    mul_res   = (op_e == MD_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
`ifdef MULDIV_EARLY_OUT_EN
    div_skip  = in_b_zero | in_ovf;
    mul_zero  = (a == '0) | (b == '0);
`else
    div_skip  = 1'b0;
    mul_zero  = 1'b0;
`endif
  end

  muldiv_sequencer_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem_reg),
    .dvsr    (dvsr),
    .q_in    (q_reg),
    .rem_out (rem_nx),
    .q_out   (q_nx)
  );

  always_comb begin
    logic [XLEN-1:0] q_f, r_f;
    if (b_zero) begin
      q_f = '1;
      r_f = a_q;
    end else if (ovf) begin
      q_f = {1'b1, {(XLEN-1){1'b0}}};
      r_f = '0;
    end else begin
      q_f = neg_q ? -q_reg : q_reg;
      r_f = neg_r ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
    end
    div_res = is_rem ? r_f : q_f;
  end

  assign accept = (state == MDS_IDLE) && start && !flush;

  always_comb begin
    state_n = state;
    done    = 1'b0;
    if (flush) begin
      state_n = MDS_IDLE;
    end else begin
      case (state)
        MDS_IDLE:
          if (start) begin
            if (op[2]) state_n = div_skip ? MDS_DIV_FIX : MDS_DIV_ITER;
            else       state_n = MDS_MUL_WAIT;
          end
        MDS_MUL_WAIT:
          if (cnt == '0) begin
            done    = 1'b1;
            state_n = MDS_IDLE;
          end
        MDS_DIV_ITER:
          if (cnt == '0) state_n = MDS_DIV_FIX;
        MDS_DIV_FIX:
          if (fix_ph) begin
            done    = 1'b1;
            state_n = MDS_IDLE;
          end
        default: state_n = MDS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MDS_IDLE;
      cnt       <= '0;
      fix_ph    <= 1'b0;
      res_stage <= '0;
      result_q  <= '0;
      a_q       <= '0;
      q_reg     <= '0;
      dvsr      <= '0;
      rem_reg   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      is_rem    <= 1'b0;
      b_zero    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_n;
      if (done) result_q <= res_stage;
      if (accept) begin
        a_q     <= a;
        dvsr    <= b_mag_in;
        q_reg   <= a_mag_in;
        rem_reg <= '0;
        neg_q   <= a_neg_in ^ b_neg_in;
        neg_r   <= a_neg_in;
        is_rem  <= op[1];
        b_zero  <= in_b_zero;
        ovf     <= in_ovf;
        fix_ph  <= 1'b0;
        if (op[2]) begin
          cnt <= CNT_W'(XLEN - 1);
        end else begin
          res_stage <= mul_res;
          cnt       <= mul_zero ? '0 : CNT_W'(MUL_CYCLES - 1);
        end
      end else begin
        case (state)
          MDS_MUL_WAIT:
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
          MDS_DIV_ITER: begin
            rem_reg <= rem_nx;
            q_reg   <= q_nx;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
          end
          // Sign fix-up is registered first so done never sits behind a negate.
          MDS_DIV_FIX:
            if (!fix_ph) begin
              res_stage <= div_res;
              fix_ph    <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

  assign busy   = (state != MDS_IDLE);
  assign stall  = (start | busy) & ~done;
  assign result = done ? res_stage : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed literal cases plus
// randomized traffic compared each cycle against an arithmetic reference.
module tb_muldiv_sequencer;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MUL_CYCLES = 2;
  localparam int          DIV_LAT    = XLEN + 2;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif
  localparam int DIV_SPECIAL_LAT = EARLY_OUT ? 2 : DIV_LAT;
  localparam int MUL_ZERO_LAT    = EARLY_OUT ? 1 : int'(MUL_CYCLES);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, stall, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  muldiv_sequencer #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sx, sy, ps;
    longint unsigned ux, uy, pu;
    logic            ovf_case;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ovf_case = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    ps = 0;
    pu = 0;
    case (o)
      3'd0: begin ps = sx * sy; return ps[31:0]; end
      3'd1: begin ps = sx * sy; return ps[63:32]; end
      3'd2: begin ps = sx * longint'(uy); return ps[63:32]; end
      3'd3: begin pu = ux * uy; return pu[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf_case) return 32'h8000_0000;
        ps = sx / sy; return ps[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        pu = ux / uy; return pu[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf_case) return 32'd0;
        ps = sx % sy; return ps[31:0];
      end
      default: begin
        if (y == 0) return x;
        pu = ux % uy; return pu[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (o[2]) begin
      if (EARLY_OUT && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
        return 2;
      return DIV_LAT;
    end
    if (EARLY_OUT && ((x == 0) || (y == 0))) return 1;
    return int'(MUL_CYCLES);
  endfunction

  // Per-cycle reference: one op in flight, done on a known cycle, result held otherwise.
  bit          m_pending = 1'b0;
  int          m_done_cyc = 0;
  logic [31:0] m_val = '0;
  logic [31:0] m_held = '0;
  logic        e_done, e_stall;

  always @(negedge clk) begin
    if (rst) begin
      m_pending = 1'b0;
      m_held    = '0;
      chk1("m_rst_busy", busy, 1'b0);
      chk1("m_rst_done", done, 1'b0);
      chk("m_rst_result", result, 32'd0);
    end else begin
      e_done  = m_pending && (cyc == m_done_cyc) && !flush;
      e_stall = (start || m_pending) && !e_done;
      chk1("m_busy", busy, m_pending);
      chk1("m_done", done, e_done);
      chk1("m_stall", stall, e_stall);
      chk("m_result", result, e_done ? m_val : m_held);
      if (m_pending) begin
        if (e_done) m_held = m_val;
        if (flush || e_done) m_pending = 1'b0;
      end else if (start && !flush) begin
        m_pending  = 1'b1;
        m_done_cyc = cyc + ref_latency(op, a, b);
        m_val      = ref_result(op, a, b);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int t0);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int lat, input logic [31:0] exp,
                           input string name);
    bit got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    chk1({name, "_done_seen"}, got, 1'b1);
    if (got) begin
      chk({name, "_latency"}, 32'(cyc - t0), 32'(lat));
      chk({name, "_result"}, result, exp);
    end
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int t0, t1, ndone, dcyc;
    logic [31:0] dres;

    vecs.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, int'(MUL_CYCLES), "mul_7_m3"});
    vecs.push_back('{3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, int'(MUL_CYCLES), "mulh_7_m3"});
    vecs.push_back('{3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, int'(MUL_CYCLES), "mulhu_7_m3"});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, int'(MUL_CYCLES), "mulhsu_m1_2"});
    vecs.push_back('{3'd0, 32'd0, 32'd1234, 32'd0, MUL_ZERO_LAT, "mul_zero"});
    vecs.push_back('{3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DIV_LAT, "div_m20_3"});
    vecs.push_back('{3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, DIV_LAT, "rem_m20_3"});
    vecs.push_back('{3'd5, 32'd20, 32'd3, 32'd6, DIV_LAT, "divu_20_3"});
    vecs.push_back('{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, DIV_SPECIAL_LAT, "div_by0"});
    vecs.push_back('{3'd6, 32'd5, 32'd0, 32'd5, DIV_SPECIAL_LAT, "rem_by0"});
    vecs.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, DIV_SPECIAL_LAT, "divu_by0"});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_SPECIAL_LAT, "div_ovf"});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_SPECIAL_LAT, "rem_ovf"});
    vecs.push_back('{3'd7, 32'd7, 32'hFFFF_FFFF, 32'd7, DIV_LAT, "remu_small"});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_stall", stall, 1'b0);
    chk("reset_result", result, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y, t0);
      wait_done(t0, vecs[i].lat, vecs[i].r, vecs[i].name);
    end

    // Flush mid-divide: no done, result keeps the previous value.
    issue(3'd4, 32'd1000, 32'd7, t0);
    goto_cycle(t0 + 10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk1("flush_busy_cleared", busy, 1'b0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_result_held", result, 32'd7);
    issue(3'd5, 32'd1000, 32'd7, t0);
    wait_done(t0, DIV_LAT, 32'd142, "after_flush");

    // Start while busy is ignored.
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, t0);
    goto_cycle(t0 + 5);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    #1 chk1("busy_start_stall", stall, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; dcyc = 0; dres = '0;
    while (cyc < t0 + 40) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        dcyc = cyc;
        dres = result;
      end
    end
    chk("busy_start_single_done", 32'(ndone), 32'd1);
    chk("busy_start_latency", 32'(dcyc - t0), 32'(DIV_LAT));
    chk("busy_start_result", dres, 32'hFFFF_FFF2);

    // Start in the done cycle is taken one cycle later.
    issue(3'd5, 32'd100, 32'd7, t0);
    goto_cycle(t0 + DIV_LAT);
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    chk1("sd_done", done, 1'b1);
    chk1("sd_stall_low", stall, 1'b0);
    chk("sd_result", result, 32'd14);
    @(posedge clk); #1;
    chk1("sd_idle_busy", busy, 1'b0);
    chk1("sd_idle_stall", stall, 1'b1);
    t1 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t1, int'(MUL_CYCLES), 32'd42, "sd_next");

    // Flush and start together in IDLE: flush wins.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'd9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk1("flush_start_not_taken", busy, 1'b0);

    // Asynchronous reset mid-divide, asserted and released off-edge.
    issue(3'd4, 32'd12345, 32'd11, t0);
    goto_cycle(t0 + 12);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_done", done, 1'b0);
    chk("async_rst_result", result, 32'd0);
    #4 rst = 1'b0;
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
    wait_done(t0, int'(MUL_CYCLES), 32'hFFFF_FFFE, "after_rst");

    // Random traffic, including flushes and starts while busy.
    repeat (3000) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 59) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    repeat (50) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
